// File: rtl/axi_conv_pkg.sv
// Definitions shared by the AXI4->AXI3 address-channel converter and its
// write-data splitter.
package axi_conv_pkg;

    localparam int unsigned AXI3_MAX_BEATS = 16;
    localparam int unsigned AXI4_LEN_BITS  = 8;
    localparam int unsigned AXI3_LEN_BITS  = $clog2(AXI3_MAX_BEATS);

    typedef enum logic {
        AXI4_LOCK_NORMAL = 1'b0,
        AXI4_LOCK_EXCL   = 1'b1
    } axi4_lock_e;

    typedef enum logic [1:0] {
        AXI3_LOCK_NORMAL = 2'b00,
        AXI3_LOCK_EXCL   = 2'b01,
        AXI3_LOCK_LOCKED = 2'b10
    } axi3_lock_e;

endpackage

// File: rtl/axi_len_fifo.sv
// Small synchronous FIFO holding {awlen, awid} for bursts whose W data is
// still to come; extra pointer bit separates full from empty.
module axi_len_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge ACLK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/axi4_to_axi3_wdata_splitter.sv
// Re-frames an AXI4 W stream into AXI3 sub-bursts (full 16-beat bursts first,
// then the remainder), asserting WLAST by beat count alone.
module axi4_to_axi3_wdata_splitter
    import axi_conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned AXI4_LEN_W = AXI4_LEN_BITS,
    parameter int unsigned AXI3_LEN_W = AXI3_LEN_BITS,
    parameter int unsigned LEN_DEPTH  = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    len_push,
    input  logic [AXI4_LEN_W-1:0]   len_in,
    input  logic [ID_WIDTH-1:0]     id_in,
    output logic                    len_full,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wlast,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic [ID_WIDTH-1:0]     m_wid,
    output logic                    m_wlast,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    output logic                    sub_done,
    output logic                    burst_done,
    output logic                    err
);

    localparam int unsigned REM_W   = AXI4_LEN_W + 1;
    localparam int unsigned ENTRY_W = AXI4_LEN_W + ID_WIDTH;
    localparam logic [AXI3_LEN_W-1:0] SUB_LAST = '1;

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_ACTIVE = 1'b1;

    logic                  state_q;
    logic                  state_d;
    logic                  fifo_pop;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    fifo_rdata;
    logic [AXI4_LEN_W-1:0] pop_len;
    logic [ID_WIDTH-1:0]   pop_id;
    logic [ID_WIDTH-1:0]   cur_id;
    logic [REM_W-1:0]      remaining;
    logic [AXI3_LEN_W-1:0] sub_cnt;
    logic                  active;
    logic                  last_beat;
    logic                  hs;

    axi_len_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (LEN_DEPTH)
    ) u_len_fifo (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .push      (len_push),
        .push_data ({len_in, id_in}),
        .full      (len_full),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .empty     (fifo_empty)
    );

    assign {pop_len, pop_id} = fifo_rdata;

    // Zero-latency pass-through while a burst is open.
    assign active    = (state_q == ST_ACTIVE);
    assign last_beat = (remaining == REM_W'(1));
    assign hs        = active & s_wvalid & m_wready;
    assign s_wready  = active & m_wready;
    assign m_wvalid  = active & s_wvalid;
    assign m_wdata   = s_wdata;
    assign m_wstrb   = s_wstrb;
    assign m_wid     = cur_id;
    assign m_wlast   = active & ((sub_cnt == SUB_LAST) | last_beat);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (hs && last_beat) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            remaining <= '0;
            sub_cnt   <= '0;
            cur_id    <= '0;
        end else if (fifo_pop) begin
            remaining <= REM_W'(pop_len) + REM_W'(1);
            sub_cnt   <= '0;
            cur_id    <= pop_id;
        end else if (hs) begin
            remaining <= remaining - REM_W'(1);
            sub_cnt   <= m_wlast ? '0 : sub_cnt + AXI3_LEN_W'(1);
        end
    end

    // A dropped push and a misplaced s_wlast both surface on err.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            sub_done   <= 1'b0;
            burst_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            sub_done   <= hs & m_wlast;
            burst_done <= hs & last_beat;
            err        <= (len_push & len_full) | (hs & (s_wlast != last_beat));
        end
    end

endmodule

// File: tb/tb_axi4_to_axi3_wdata_splitter.sv
// Randomized bench for the W-channel splitter: expected AXI3 beats are built
// from burst lengths and compared beat-by-beat, with pulse timing checks.
module tb_axi4_to_axi3_wdata_splitter;

    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned IW = 4;
    localparam int unsigned LW = 8;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic          len_push = 1'b0;
    logic [LW-1:0] len_in = '0;
    logic [IW-1:0] id_in = '0;
    logic          len_full;
    logic [DW-1:0] s_wdata = '0;
    logic [SW-1:0] s_wstrb = '0;
    logic          s_wlast = 1'b0;
    logic          s_wvalid = 1'b0;
    logic          s_wready;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_wstrb;
    logic [IW-1:0] m_wid;
    logic          m_wlast;
    logic          m_wvalid;
    logic          m_wready = 1'b0;
    logic          sub_done;
    logic          burst_done;
    logic          err;

    always #5 ACLK = ~ACLK;

    axi4_to_axi3_wdata_splitter #(
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .AXI4_LEN_W (LW),
        .AXI3_LEN_W (4),
        .LEN_DEPTH  (4)
    ) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .len_push   (len_push),
        .len_in     (len_in),
        .id_in      (id_in),
        .len_full   (len_full),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .s_wlast    (s_wlast),
        .s_wvalid   (s_wvalid),
        .s_wready   (s_wready),
        .m_wdata    (m_wdata),
        .m_wstrb    (m_wstrb),
        .m_wid      (m_wid),
        .m_wlast    (m_wlast),
        .m_wvalid   (m_wvalid),
        .m_wready   (m_wready),
        .sub_done   (sub_done),
        .burst_done (burst_done),
        .err        (err)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last_in;
    } src_beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [IW-1:0] id;
        logic          last;
        logic          final_beat;
        logic          bad_last;
    } exp_beat_t;

    typedef struct packed {
        logic [LW-1:0] len;
        logic [IW-1:0] id;
        logic          drop;
    } push_t;

    src_beat_t src_q[$];
    exp_beat_t exp_q[$];
    push_t     push_q[$];

    int checks = 0;
    int errors = 0;
    int n_sub, n_burst, n_err;
    int exp_sub, exp_burst, exp_err;
    logic sub_pend = 1'b0, burst_pend = 1'b0, err_pend = 1'b0;
    logic src_hs = 1'b0;
    logic cur_push_drop = 1'b0;
    int valid_pct = 100;
    int ready_pct = 100;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected AXI3 framing: WLAST every 16th beat and on the final beat.
    function automatic void queue_data(input int len, input logic [IW-1:0] id, input int bad_beat);
        for (int k = 1; k <= len + 1; k++) begin
            src_beat_t s;
            exp_beat_t e;
            s.data       = $urandom;
            s.strb       = SW'($urandom);
            s.last_in    = (k == len + 1) || (k == bad_beat);
            e.data       = s.data;
            e.strb       = s.strb;
            e.id         = id;
            e.last       = (k % 16 == 0) || (k == len + 1);
            e.final_beat = (k == len + 1);
            e.bad_last   = (s.last_in != e.final_beat);
            src_q.push_back(s);
            exp_q.push_back(e);
        end
        exp_sub   += (len + 16) / 16;
        exp_burst += 1;
        if (bad_beat > 0 && bad_beat <= len) exp_err += 1;
    endfunction

    function automatic void queue_burst(input int len, input logic [IW-1:0] id, input int bad_beat);
        push_q.push_back({LW'(len), id, 1'b0});
        queue_data(len, id, bad_beat);
    endfunction

    function automatic void clear_counts();
        n_sub = 0; n_burst = 0; n_err = 0;
        exp_sub = 0; exp_burst = 0; exp_err = 0;
    endfunction

    task automatic monitor_step();
        exp_beat_t e;
        check_eq("sub_done", 64'(sub_done), 64'(sub_pend));
        check_eq("burst_done", 64'(burst_done), 64'(burst_pend));
        check_eq("err", 64'(err), 64'(err_pend));
        if (burst_pend) begin
            check_eq("bubble_s_wready", 64'(s_wready), 64'(0));
            check_eq("bubble_m_wvalid", 64'(m_wvalid), 64'(0));
        end
        n_sub   += int'(sub_done);
        n_burst += int'(burst_done);
        n_err   += int'(err);
        sub_pend   = 1'b0;
        burst_pend = 1'b0;
        err_pend   = len_push & cur_push_drop;
        src_hs     = s_wvalid & s_wready;
        if (m_wvalid && m_wready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_beat", 64'(m_wvalid & m_wready), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check_eq("m_wdata", 64'(m_wdata), 64'(e.data));
                check_eq("m_wstrb", 64'(m_wstrb), 64'(e.strb));
                check_eq("m_wid", 64'(m_wid), 64'(e.id));
                check_eq("m_wlast", 64'(m_wlast), 64'(e.last));
                sub_pend   = e.last;
                burst_pend = e.final_beat;
                err_pend   = err_pend | e.bad_last;
            end
        end
    endtask

    task automatic driver_step();
        push_t p;
        if (src_hs) void'(src_q.pop_front());
        if (!(s_wvalid && !src_hs))
            s_wvalid = (src_q.size() > 0) && ($urandom_range(99) < valid_pct);
        if (s_wvalid) begin
            s_wdata = src_q[0].data;
            s_wstrb = src_q[0].strb;
            s_wlast = src_q[0].last_in;
        end else begin
            s_wdata = $urandom;
            s_wlast = 1'b0;
        end
        m_wready = ($urandom_range(99) < ready_pct);
        if (push_q.size() > 0) begin
            p = push_q.pop_front();
            len_push = 1'b1;
            len_in = p.len;
            id_in = p.id;
            cur_push_drop = p.drop;
        end else begin
            len_push = 1'b0;
            cur_push_drop = 1'b0;
        end
    endtask

    task automatic cycle();
        @(negedge ACLK);
        monitor_step();
        @(posedge ACLK);
        #1;
        driver_step();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0 || push_q.size() > 0 ||
                sub_pend || burst_pend || err_pend) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) check_eq("drain_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic end_scenario(input string name);
        check_eq({name, "_sub_count"}, 64'(n_sub), 64'(exp_sub));
        check_eq({name, "_burst_count"}, 64'(n_burst), 64'(exp_burst));
        check_eq({name, "_err_count"}, 64'(n_err), 64'(exp_err));
        check_eq({name, "_len_full"}, 64'(len_full), 64'(0));
    endtask

    task automatic check_reset_outputs(input string name);
        check_eq({name, "_len_full"}, 64'(len_full), 64'(0));
        check_eq({name, "_s_wready"}, 64'(s_wready), 64'(0));
        check_eq({name, "_m_wvalid"}, 64'(m_wvalid), 64'(0));
        check_eq({name, "_m_wlast"}, 64'(m_wlast), 64'(0));
        check_eq({name, "_m_wid"}, 64'(m_wid), 64'(0));
        check_eq({name, "_pulses"}, 64'({sub_done, burst_done, err}), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lens[6];
        #2;
        check_reset_outputs("reset");
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        ARESETN = 1'b1;

        // Single short burst.
        clear_counts(); valid_pct = 100; ready_pct = 100;
        queue_burst(3, 4'd2, 0);
        drain(200);
        end_scenario("len3");

        // One full sub-burst plus a single-beat remainder.
        clear_counts();
        queue_burst(16, 4'd7, 0);
        drain(200);
        end_scenario("len16");

        // Maximum AXI4 burst.
        clear_counts();
        queue_burst(255, IW'($urandom), 0);
        drain(1000);
        end_scenario("len255");

        // Downstream backpressure.
        clear_counts(); ready_pct = 50;
        queue_burst(31, 4'd9, 0);
        drain(1000);
        end_scenario("len31_bp");

        // Back-to-back random bursts with throttling on both sides.
        clear_counts(); valid_pct = 70; ready_pct = 70;
        lens[0] = 0; lens[1] = 15;
        for (int i = 2; i < 6; i++) lens[i] = $urandom_range(0, 47);
        for (int i = 0; i < 6; i++) queue_burst(lens[i], IW'($urandom), 0);
        drain(2000);
        end_scenario("random");

        // Fill the length queue while the first burst waits for data.
        clear_counts(); valid_pct = 100; ready_pct = 100;
        push_q.push_back({LW'(2), 4'd1, 1'b0});
        for (int i = 0; i < 4; i++) push_q.push_back({LW'(i + 1), IW'(i + 3), 1'b0});
        push_q.push_back({LW'(9), 4'd15, 1'b1});
        exp_err += 1;
        repeat (8) cycle();
        check_eq("full_len_full", 64'(len_full), 64'(1));
        check_eq("full_err_count", 64'(n_err), 64'(1));
        queue_data(2, 4'd1, 0);
        for (int i = 0; i < 4; i++) queue_data(i + 1, IW'(i + 3), 0);
        drain(500);
        end_scenario("full");
        s_wvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            check_eq("dropped_entry_idle", 64'(m_wvalid | s_wready), 64'(0));
        end
        @(posedge ACLK); #1;
        s_wvalid = 1'b0;

        // Early s_wlast: flagged, framing unchanged.
        clear_counts();
        queue_burst(7, 4'd6, 5);
        drain(200);
        end_scenario("early_wlast");

        // Reset in the middle of a burst with another one queued.
        clear_counts();
        queue_burst(31, 4'd5, 0);
        queue_burst(3, 4'd1, 0);
        repeat (12) cycle();
        ARESETN = 1'b0;
        #1;
        check_reset_outputs("midreset");
        src_q.delete(); exp_q.delete(); push_q.delete();
        sub_pend = 1'b0; burst_pend = 1'b0; err_pend = 1'b0; src_hs = 1'b0;
        len_push = 1'b0; cur_push_drop = 1'b0;
        s_wvalid = 1'b1; m_wready = 1'b1;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        check_reset_outputs("in_reset");
        ARESETN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            check_reset_outputs("post_reset_flushed");
        end
        @(posedge ACLK); #1;
        s_wvalid = 1'b0;

        // Recovery after reset.
        clear_counts();
        queue_burst(5, 4'd3, 0);
        drain(200);
        end_scenario("recover");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
